chaos_key_sequencer: RTL and testbench



---
 rtl/chaos_key_pkg.sv | 23 ++
 rtl/chaos_key_fifo.sv | 55 +++++
 rtl/chaos_key_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_chaos_key_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chaos_key_pkg.sv
// Shared types and helpers for the chaos-key sequencer slice.
package chaos_key_pkg;

  typedef enum logic [2:0] {
    ST_SEED,
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DROP
  } state_e;

  // 1000.0 as float32, the usual scale handed to the core at seed time
  localparam logic [31:0] DEFAULT_SHIFT = 32'h447a0000;

  // Core bytes packed W:Z:Y:X from MSB to LSB
  function automatic logic [31:0] pack_code(input logic [7:0] x,
                                            input logic [7:0] y,
                                            input logic [7:0] z,
                                            input logic [7:0] w);
    return {w, z, y, x};
  endfunction

endpackage

// File: rtl/chaos_key_fifo.sv
// Synchronous key-word FIFO with flush; DEPTH must be a power of two >= 2.
module chaos_key_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [LW-1:0]    level_q;

  // Storage write; flush wins over a same-cycle push
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i && !rst_i) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally modulo DEPTH; level tracks push/pop balance
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + AW'(1);
      if (pop_i)  rptr_q <= rptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign level_o = level_q;
  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);

endmodule

// File: rtl/chaos_key_sequencer.sv
// Chaos-key core controller: seeds/steps the core, packs CODE bytes into
// 32-bit words, buffers them and serves two consumers round-robin.
// Optional build macro CHAOS_KEY_WHITEN_EN: XOR each pushed word with the
// previously pushed raw word.
module chaos_key_sequencer
  import chaos_key_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          START,
  input  logic                          RESEED,
  input  logic [31:0]                   SEED_SHIFT,
  output logic                          CORE_STEP,
  output logic                          CORE_RESET,
  output logic [31:0]                   CORE_SHIFT,
  input  logic                          CORE_DONE,
  input  logic [7:0]                    CORE_CODE_X,
  input  logic [7:0]                    CORE_CODE_Y,
  input  logic [7:0]                    CORE_CODE_Z,
  input  logic [7:0]                    CORE_CODE_W,
  input  logic [1:0]                    REQ,
  output logic [1:0]                    GNT,
  output logic [31:0]                   RD_DATA,
  output logic                          RD_VALID,
  output logic [$clog2(FIFO_DEPTH):0]   LEVEL,
  output logic                          BUSY,
  output logic                          ERR
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic          active_q;
  logic          need_load_q, need_load_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          err_q, err_d;
  logic [31:0]   shift_q;
  logic          push, pop, step, core_rst;
  logic          fifo_full, fifo_empty;
  logic [31:0]   fifo_head;
  logic [31:0]   raw_word, push_word;
  logic [1:0]    gnt_d, gnt_q;
  logic [31:0]   rd_data_q;
  logic          rd_valid_q;
  logic          ptr_q;

  assign raw_word = pack_code(CORE_CODE_X, CORE_CODE_Y, CORE_CODE_Z, CORE_CODE_W);

`ifdef CHAOS_KEY_WHITEN_EN
  logic [31:0] prev_q;

  // Previous raw word for whitening; restarts from zero at every seed
  always_ff @(posedge CLK) begin
    if (RESET) begin
      prev_q <= '0;
    end else if (active_q && state_q == ST_SEED) begin
      prev_q <= '0;
    end else if (push) begin
      prev_q <= raw_word;
    end
  end

  assign push_word = raw_word ^ prev_q;
`else
  assign push_word = raw_word;
`endif

  // active_q holds the state in SEED for the first cycle after reset so
  // all outputs read 0 while RESET is asserted and SEED follows release.
  // State register and sticky fault bookkeeping
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_SEED;
      active_q    <= 1'b0;
      need_load_q <= 1'b1;
      tcnt_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_q    <= 1'b1;
      need_load_q <= need_load_d;
      tcnt_q      <= tcnt_d;
      err_q       <= err_d;
    end
  end

  // Next-state and core-control decode
  always_comb begin
    state_d     = state_q;
    need_load_d = need_load_q;
    tcnt_d      = '0;
    err_d       = err_q;
    push        = 1'b0;
    step        = 1'b0;
    core_rst    = 1'b0;
    case (state_q)
      ST_SEED: begin
        core_rst    = 1'b1;
        need_load_d = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_IDLE: begin
        if (START && !fifo_full) state_d = need_load_q ? ST_LOAD : ST_RUN;
      end
      ST_LOAD: begin
        step        = 1'b1;
        need_load_d = 1'b0;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        step = 1'b1;
        if (CORE_DONE) begin
          push    = 1'b1;
          state_d = ST_DROP;
        end else if (tcnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_SEED;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      ST_DROP: begin
        state_d = (START && !fifo_full) ? ST_RUN : ST_IDLE;
      end
      default: state_d = ST_SEED;
    endcase
    if (RESEED) begin
      state_d = ST_SEED;
      push    = 1'b0;
      err_d   = 1'b0;
    end
    if (!active_q) begin
      state_d  = ST_SEED;
      push     = 1'b0;
      step     = 1'b0;
      core_rst = 1'b0;
    end
  end

  // Seed scale captured on entry to SEED and held until the next one
  always_ff @(posedge CLK) begin
    if (RESET) begin
      shift_q <= '0;
    end else if (state_d == ST_SEED) begin
      shift_q <= SEED_SHIFT;
    end
  end

  // Round-robin pick: favour ptr_q, else the other requester
  always_comb begin
    pop   = 1'b0;
    gnt_d = '0;
    if (!RESEED && !fifo_empty && (REQ != 2'b00)) begin
      pop = 1'b1;
      if (REQ[ptr_q]) gnt_d[ptr_q]  = 1'b1;
      else            gnt_d[~ptr_q] = 1'b1;
    end
  end

  // Registered grant with the popped head word
  always_ff @(posedge CLK) begin
    if (RESET) begin
      gnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      ptr_q      <= 1'b0;
    end else begin
      gnt_q      <= gnt_d;
      rd_valid_q <= pop;
      if (pop) begin
        rd_data_q <= fifo_head;
        ptr_q     <= gnt_d[0];
      end
    end
  end

  chaos_key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .flush_i (RESEED),
    .push_i  (push),
    .wdata_i (push_word),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .level_o (LEVEL),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign CORE_STEP  = step;
  assign CORE_RESET = core_rst;
  assign CORE_SHIFT = shift_q;
  assign GNT        = gnt_q;
  assign RD_DATA    = rd_data_q;
  assign RD_VALID   = rd_valid_q;
  assign BUSY       = active_q && (state_q != ST_IDLE);
  assign ERR        = err_q;

endmodule

// File: tb/tb_chaos_key_sequencer.sv
// Scoreboard bench for chaos_key_sequencer with a stub chaos core.
module tb_chaos_key_sequencer;
  import chaos_key_pkg::*;

`ifdef CHAOS_KEY_WHITEN_EN
  localparam bit WHITEN = 1'b1;
`else
  localparam bit WHITEN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET, START, RESEED;
  logic [31:0] SEED_SHIFT;
  logic        CORE_STEP, CORE_RESET, CORE_DONE;
  logic [31:0] CORE_SHIFT;
  logic [7:0]  CORE_CODE_X, CORE_CODE_Y, CORE_CODE_Z, CORE_CODE_W;
  logic [1:0]  REQ, GNT;
  logic [31:0] RD_DATA;
  logic        RD_VALID, BUSY, ERR;
  logic [3:0]  LEVEL;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [1:0]  gnt_exp[$];

  // stub core state
  int          stub_cnt = 0;
  int          stub_idx = 0;
  logic        stub_en  = 1'b1;
  logic        wh_on    = 1'b0;
  int          wh_base  = 0;
  logic [31:0] prev_raw = '0;
  logic [31:0] cur_raw;

  always #5 CLK = ~CLK;

  chaos_key_sequencer #(
    .FIFO_DEPTH (8),
    .TIMEOUT    (64)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .START       (START),
    .RESEED      (RESEED),
    .SEED_SHIFT  (SEED_SHIFT),
    .CORE_STEP   (CORE_STEP),
    .CORE_RESET  (CORE_RESET),
    .CORE_SHIFT  (CORE_SHIFT),
    .CORE_DONE   (CORE_DONE),
    .CORE_CODE_X (CORE_CODE_X),
    .CORE_CODE_Y (CORE_CODE_Y),
    .CORE_CODE_Z (CORE_CODE_Z),
    .CORE_CODE_W (CORE_CODE_W),
    .REQ         (REQ),
    .GNT         (GNT),
    .RD_DATA     (RD_DATA),
    .RD_VALID    (RD_VALID),
    .LEVEL       (LEVEL),
    .BUSY        (BUSY),
    .ERR         (ERR)
  );

  // Directed raw words: first is 44332211, whitening pair is A5A5A5A5/0F0F0F0F
  assign cur_raw = (wh_on && stub_idx == wh_base)     ? 32'hA5A5A5A5 :
                   (wh_on && stub_idx == wh_base + 1) ? 32'h0F0F0F0F :
                   32'h44332211 + 32'h01010101 * 32'(stub_idx);
  assign CORE_CODE_X = cur_raw[7:0];
  assign CORE_CODE_Y = cur_raw[15:8];
  assign CORE_CODE_Z = cur_raw[23:16];
  assign CORE_CODE_W = cur_raw[31:24];
  assign CORE_DONE   = CORE_STEP && stub_en && (stub_cnt == 52);

  function automatic logic [31:0] exp_word(input logic [31:0] raw, input logic [31:0] prev);
    return WHITEN ? (raw ^ prev) : raw;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_level(input int lv, input int budget, input string nm);
    int k = 0;
    while (LEVEL != lv && k < budget) begin
      tick();
      k++;
    end
    n_checks++;
    if (LEVEL != lv) begin
      n_fail++;
      $display("FAIL %s: LEVEL=%0d after %0d cycles, required %0d", nm, LEVEL, k, lv);
    end
  endtask

  // Stub core: counts STEP-high cycles; on DONE the expected word enters the scoreboard
  always @(posedge CLK) begin
    stub_cnt <= CORE_STEP ? stub_cnt + 1 : 0;
    if (RESET || RESEED) begin
      exp_q.delete();
      prev_raw <= '0;
    end else if (CORE_RESET) begin
      prev_raw <= '0;
    end else if (CORE_DONE) begin
      exp_q.push_back(exp_word(cur_raw, prev_raw));
      prev_raw <= cur_raw;
      stub_idx <= stub_idx + 1;
    end
  end

  // Monitor: every presented word is matched against the scoreboard
  always @(negedge CLK) begin
    logic [1:0]  lg;
    logic [31:0] ld;
    if (RD_VALID) begin
      if (exp_q.size() == 0 || gnt_exp.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_grant: GNT=%b RD_DATA=%h, required no grant", GNT, RD_DATA);
      end else begin
        lg = gnt_exp.pop_front();
        ld = exp_q.pop_front();
        check("grant", 32'(GNT), 32'(lg));
        check("rd_data", RD_DATA, ld);
      end
    end else if (GNT != 2'b00) begin
      check("gnt_without_valid", 32'(GNT), 32'h0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int k;
    int steps;
    RESET = 1'b1; START = 1'b0; RESEED = 1'b0; REQ = 2'b00;
    SEED_SHIFT = DEFAULT_SHIFT;
    repeat (3) tick();
    check("rst_core_reset", 32'(CORE_RESET), 32'h0);
    check("rst_core_step",  32'(CORE_STEP),  32'h0);
    check("rst_core_shift", CORE_SHIFT,      32'h0);
    check("rst_level",      32'(LEVEL),      32'h0);
    check("rst_gnt",        32'(GNT),        32'h0);
    check("rst_rd_valid",   32'(RD_VALID),   32'h0);
    check("rst_busy",       32'(BUSY),       32'h0);
    check("rst_err",        32'(ERR),        32'h0);

    RESET = 1'b0;
    tick();
    check("seed_core_reset", 32'(CORE_RESET), 32'h1);
    check("seed_core_step",  32'(CORE_STEP),  32'h0);
    check("seed_shift",      CORE_SHIFT,      DEFAULT_SHIFT);
    check("seed_busy",       32'(BUSY),       32'h1);
    tick();
    check("idle_core_reset", 32'(CORE_RESET), 32'h0);
    check("idle_busy",       32'(BUSY),       32'h0);

    // first word: LOAD + 52 RUN cycles, word 44332211
    START = 1'b1;
    k = 0; steps = 0;
    while (LEVEL != 1 && k < 200) begin
      tick();
      k++;
      if (CORE_STEP) steps++;
    end
    check("t1_level", 32'(LEVEL), 32'd1);
    check("t1_step_cycles", 32'(steps), 32'd53);
    check("t1_drop_step", 32'(CORE_STEP), 32'h0);
    START = 1'b0;
    tick(); tick();
    check("t1_idle_busy", 32'(BUSY), 32'h0);

    // fill to 8, then a single request from requester 0
    START = 1'b1;
    wait_level(8, 600, "t2_fill");
    repeat (10) tick();
    check("t2_level_sat", 32'(LEVEL), 32'd8);
    check("t2_step_idle", 32'(CORE_STEP), 32'h0);
    check("t2_busy_idle", 32'(BUSY), 32'h0);
    gnt_exp.push_back(2'b01);
    REQ = 2'b01;
    tick();
    REQ = 2'b00;
    check("t2_level_pop", 32'(LEVEL), 32'd7);
    k = 0;
    while (!CORE_STEP && k < 5) begin
      tick();
      k++;
    end
    check("t2_restart_step", 32'(CORE_STEP), 32'h1);
    wait_level(8, 100, "t2_refill");
    START = 1'b0;
    tick();
    check("t2_busy_after", 32'(BUSY), 32'h0);

    // lone requester 1 drains four back-to-back, then alternate with both
    repeat (4) gnt_exp.push_back(2'b10);
    REQ = 2'b10;
    repeat (4) tick();
    REQ = 2'b00;
    check("t3_level_half", 32'(LEVEL), 32'd4);
    gnt_exp.push_back(2'b01);
    gnt_exp.push_back(2'b10);
    gnt_exp.push_back(2'b01);
    gnt_exp.push_back(2'b10);
    REQ = 2'b11;
    repeat (4) tick();
    repeat (2) begin
      tick();
      check("t3_gnt_empty", 32'(GNT), 32'h0);
      check("t3_valid_empty", 32'(RD_VALID), 32'h0);
    end
    REQ = 2'b00;
    check("t3_level_zero", 32'(LEVEL), 32'd0);

    // core never finishes: 64 RUN cycles then fault and SEED
    stub_en = 1'b0;
    START = 1'b1;
    k = 0; steps = 0;
    while (!CORE_RESET && k < 200) begin
      tick();
      k++;
      if (CORE_STEP) steps++;
    end
    check("t4_run_cycles", 32'(steps), 32'd64);
    check("t4_seed", 32'(CORE_RESET), 32'h1);
    check("t4_err", 32'(ERR), 32'h1);
    START = 1'b0;
    repeat (3) tick();
    check("t4_err_sticky", 32'(ERR), 32'h1);
    check("t4_busy_idle", 32'(BUSY), 32'h0);
    RESEED = 1'b1;
    tick();
    RESEED = 1'b0;
    check("t4_err_clear", 32'(ERR), 32'h0);
    check("t4_reseed_seed", 32'(CORE_RESET), 32'h1);
    stub_en = 1'b1;
    tick();

    // reseed 20 cycles into a RUN with three words buffered
    START = 1'b1;
    wait_level(3, 250, "t5_fill");
    k = 0; steps = 0;
    while (steps < 20 && k < 60) begin
      tick();
      k++;
      if (CORE_STEP) steps++;
    end
    check("t5_run_cycles", 32'(steps), 32'd20);
    SEED_SHIFT = 32'h3F800000;
    RESEED = 1'b1;
    tick();
    RESEED = 1'b0;
    START  = 1'b0;
    check("t5_level_flush", 32'(LEVEL), 32'd0);
    check("t5_new_shift", CORE_SHIFT, 32'h3F800000);
    check("t5_seed", 32'(CORE_RESET), 32'h1);
    repeat (60) tick();
    check("t5_no_push", 32'(LEVEL), 32'd0);

    // whitening pair A5A5A5A5 then 0F0F0F0F
    wh_base = stub_idx;
    wh_on   = 1'b1;
    START   = 1'b1;
    wait_level(2, 200, "t6_fill");
    START = 1'b0;
    gnt_exp.push_back(2'b01);
    gnt_exp.push_back(2'b01);
    REQ = 2'b01;
    repeat (2) tick();
    REQ = 2'b00;
    repeat (3) tick();
    check("t6_level_zero", 32'(LEVEL), 32'd0);
    check("sb_data_left", 32'(exp_q.size()), 32'd0);
    check("sb_gnt_left", 32'(gnt_exp.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
